// File: rtl/lut_multiplier_nb_seq_if.sv
// Handshake and data bundle for the radix-4 LUT sequential multiplier.
// master = operand producer / result consumer, slave = the multiplier.
interface lut_multiplier_nb_seq_if #(
    parameter int WIDTH = 8
);
    logic                   start_valid;
    logic                   start_ready;
    logic [WIDTH-1:0]       source_number_0;
    logic [WIDTH-1:0]       source_number_1;
    logic [2*WIDTH-1:0]     result;
    logic                   result_valid;
    logic                   result_ready;
    logic                   busy;

    modport master (
        output start_valid, source_number_0, source_number_1, result_ready,
        input  start_ready, result, result_valid, busy
    );

    modport slave (
        input  start_valid, source_number_0, source_number_1, result_ready,
        output start_ready, result, result_valid, busy
    );
endinterface

// File: rtl/lut_multiplier_nb_seq.sv
// Sequential unsigned multiplier, one 2-bit multiplier digit per cycle via a 0/A/2A/3A LUT.
// Optional macro LUT_MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier digits are all zero.
module lut_multiplier_nb_seq #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    lut_multiplier_nb_seq_if.slave  bus
);
    localparam int DIGITS = WIDTH / 2;
    localparam int CW     = $clog2(DIGITS) + 1;
    localparam int PW     = WIDTH + 2;
    localparam int RW     = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [RW-1:0]      acc;
    logic [CW-1:0]      count;
    logic               start_ready_r;
    logic               result_valid_r;
    logic               busy_r;

    logic [PW-1:0]      partial;
    logic [RW-1:0]      next_acc;
    logic [WIDTH-1:0]   b_next;
    logic               last_digit;
    logic               finish;

    function automatic logic [PW-1:0] lut_partial(input logic [WIDTH-1:0] a, input logic [1:0] d);
        logic [PW-1:0] a_ext;
        a_ext = PW'(a);
        case (d)
            2'd0:    return '0;
            2'd1:    return a_ext;
            2'd2:    return a_ext << 1;
            default: return (a_ext << 1) + a_ext;
        endcase
    endfunction

    always_comb begin
        partial    = lut_partial(a_reg, b_reg[1:0]);
        // The accumulator is full product width, so the weighted add cannot overflow.
        next_acc   = acc + (RW'(partial) << {count, 1'b0});
        b_next     = b_reg >> 2;
        last_digit = (count == CW'(DIGITS - 1));
`ifdef LUT_MULT_EARLY_EXIT_EN
        finish     = last_digit || (b_next == '0);
`else
        finish     = last_digit;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            acc            <= '0;
            count          <= '0;
            start_ready_r  <= 1'b1;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_reg         <= bus.source_number_0;
                        b_reg         <= bus.source_number_1;
                        acc           <= '0;
                        count         <= '0;
                        state         <= CALC;
                        start_ready_r <= 1'b0;
                        busy_r        <= 1'b1;
                    end
                end
                CALC: begin
                    acc   <= next_acc;
                    b_reg <= b_next;
                    count <= count + 1'b1;
                    if (finish) begin
                        state          <= DONE;
                        result_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    // acc is left untouched so the product stays visible until the next accept.
                    if (bus.result_ready) begin
                        state          <= IDLE;
                        result_valid_r <= 1'b0;
                        busy_r         <= 1'b0;
                        start_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    result_valid_r <= 1'b0;
                    busy_r         <= 1'b0;
                    start_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.start_ready  = start_ready_r;
    assign bus.result_valid = result_valid_r;
    assign bus.busy         = busy_r;
    assign bus.result       = acc;
endmodule

// File: tb/tb_lut_multiplier_nb_seq.sv
// Directed-vector bench for lut_multiplier_nb_seq (WIDTH=8 table plus WIDTH=16 random products).
module tb_lut_multiplier_nb_seq;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

`ifdef LUT_MULT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    lut_multiplier_nb_seq_if #(.WIDTH(8))  bus8();
    lut_multiplier_nb_seq_if #(.WIDTH(16)) bus16();

    lut_multiplier_nb_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .resetn(resetn), .bus(bus8));
    lut_multiplier_nb_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .resetn(resetn), .bus(bus16));

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        int          early_cyc;
        int          hold;
    } vec_t;

    vec_t vecs[10];

    // One WIDTH=8 transaction; calc cycles are counted from the accepting edge (exclusive).
    // During a non-zero hold, start_valid is pulsed with other operands and must be ignored.
    task automatic txn8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] prod,
                        input int exp_cyc, input int hold, input string tag);
        int cyc;
        cyc = 0;
        while (!bus8.start_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        chk1($sformatf("%s idle_ready", tag), bus8.start_ready, 1'b1);
        bus8.source_number_0 = a;
        bus8.source_number_1 = b;
        bus8.start_valid     = 1'b1;
        @(posedge clk); #1;
        bus8.start_valid = 1'b0;
        chk1($sformatf("%s busy_calc", tag), bus8.busy, 1'b1);
        chk1($sformatf("%s ready_calc", tag), bus8.start_ready, 1'b0);
        chk($sformatf("%s result_cleared", tag), 32'(bus8.result), 32'h0);
        cyc = 0;
        while (!bus8.result_valid && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        chk($sformatf("%s calc_cycles", tag), cyc, exp_cyc);
        chk($sformatf("%s result", tag), 32'(bus8.result), 32'(prod));
        chk1($sformatf("%s ready_done", tag), bus8.start_ready, 1'b0);
        for (int i = 0; i < hold; i++) begin
            bus8.start_valid     = (i % 2 == 0);
            bus8.source_number_0 = ~a;
            bus8.source_number_1 = ~b;
            @(posedge clk); #1;
            chk1($sformatf("%s hold_valid[%0d]", tag, i), bus8.result_valid, 1'b1);
            chk($sformatf("%s hold_result[%0d]", tag, i), 32'(bus8.result), 32'(prod));
            chk1($sformatf("%s hold_ready[%0d]", tag, i), bus8.start_ready, 1'b0);
        end
        bus8.start_valid  = 1'b0;
        bus8.result_ready = 1'b1;
        @(posedge clk); #1;
        bus8.result_ready = 1'b0;
        chk1($sformatf("%s back_idle_ready", tag), bus8.start_ready, 1'b1);
        chk1($sformatf("%s back_idle_valid", tag), bus8.result_valid, 1'b0);
        chk1($sformatf("%s back_idle_busy", tag), bus8.busy, 1'b0);
        chk($sformatf("%s result_kept", tag), 32'(bus8.result), 32'(prod));
    endtask

    task automatic txn16(input int n);
        logic [15:0] a;
        logic [15:0] b;
        int cyc;
        a = 16'($urandom);
        b = 16'($urandom);
        if (n % 10 == 0) b = 16'h0;
        if (n % 10 == 1) a = 16'hFFFF;
        if (n % 10 == 2) begin a = 16'hFFFF; b = 16'hFFFF; end
        bus16.source_number_0 = a;
        bus16.source_number_1 = b;
        bus16.start_valid     = 1'b1;
        @(posedge clk); #1;
        bus16.start_valid = 1'b0;
        cyc = 0;
        while (!bus16.result_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        chk($sformatf("w16 product[%0d] %0h*%0h", n, a, b), bus16.result, 32'(a) * 32'(b));
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
        end
        bus16.result_ready = 1'b1;
        @(posedge clk); #1;
        bus16.result_ready = 1'b0;
    endtask

    initial begin
        int first_rdy;
        int second_rdy;
        int cyc;
        bit saw_valid;

        vecs[0] = '{8'hFF, 8'hFF, 16'hFE01, 4, 0};
        vecs[1] = '{8'h0D, 8'h0B, 16'h008F, 2, 0};
        vecs[2] = '{8'h00, 8'h37, 16'h0000, 3, 0};
        vecs[3] = '{8'h12, 8'h03, 16'h0036, 1, 0};
        vecs[4] = '{8'h05, 8'h06, 16'h001E, 2, 0};
        vecs[5] = '{8'hA5, 8'h00, 16'h0000, 1, 0};
        vecs[6] = '{8'h80, 8'h40, 16'h2000, 4, 0};
        vecs[7] = '{8'h7F, 8'hC3, 16'h60BD, 4, 10};
        vecs[8] = '{8'h01, 8'hFF, 16'h00FF, 4, 2};
        vecs[9] = '{8'hFF, 8'h01, 16'h00FF, 1, 0};

        resetn = 1'b0;
        bus8.start_valid = 1'b0;  bus8.result_ready = 1'b0;
        bus8.source_number_0 = '0; bus8.source_number_1 = '0;
        bus16.start_valid = 1'b0; bus16.result_ready = 1'b0;
        bus16.source_number_0 = '0; bus16.source_number_1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset start_ready", bus8.start_ready, 1'b1);
        chk1("reset result_valid", bus8.result_valid, 1'b0);
        chk1("reset busy", bus8.busy, 1'b0);
        chk("reset result", 32'(bus8.result), 32'h0);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            txn8(vecs[i].a, vecs[i].b, vecs[i].prod, EARLY ? vecs[i].early_cyc : 4,
                 vecs[i].hold, $sformatf("vec%0d", i));

        // Back-to-back with start_valid and result_ready held high: ready reappears every WIDTH/2+2 cycles.
        bus8.source_number_0 = 8'h0D;
        bus8.source_number_1 = 8'h0B;
        bus8.start_valid     = 1'b1;
        bus8.result_ready    = 1'b1;
        first_rdy = -1; second_rdy = -1; cyc = 0;
        while (second_rdy < 0 && cyc < 40) begin
            if (bus8.start_ready) begin
                if (first_rdy < 0) first_rdy = cyc;
                else second_rdy = cyc;
            end
            if (second_rdy < 0) begin
                @(posedge clk); #1; cyc++;
            end
        end
        bus8.start_valid  = 1'b0;
        bus8.result_ready = 1'b0;
        chk("ii interval", second_rdy - first_rdy, EARLY ? 4 : 6);
        chk("ii result", 32'(bus8.result), 32'h008F);

        // Asynchronous reset during the second CALC cycle of a full-length product.
        bus8.source_number_0 = 8'hFF;
        bus8.source_number_1 = 8'hFF;
        bus8.start_valid     = 1'b1;
        @(posedge clk); #1;
        bus8.start_valid = 1'b0;
        @(posedge clk); #1;
        chk1("abort busy_before", bus8.busy, 1'b1);
        resetn = 1'b0;
        #1;
        chk1("abort start_ready", bus8.start_ready, 1'b1);
        chk1("abort busy", bus8.busy, 1'b0);
        chk1("abort result_valid", bus8.result_valid, 1'b0);
        chk("abort result", 32'(bus8.result), 32'h0);
        @(posedge clk); #3;
        resetn = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus8.result_valid) saw_valid = 1'b1;
        end
        chk1("abort no_valid_pulse", saw_valid, 1'b0);
        chk1("abort idle_after", bus8.start_ready, 1'b1);
        txn8(8'h05, 8'h06, 16'h001E, EARLY ? 2 : 4, 0, "post_abort");

        for (int n = 0; n < 1000; n++)
            txn16(n);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
